// File: rtl/seq_mult_nxn_pkg.sv
// seq_mult_nxn_pkg: shared state encoding and magnitude helper for seq_mult_nxn.
package seq_mult_pkg;
  localparam int MAX_WIDTH = 32;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  // v holds a w-bit two's complement value zero-extended to MAX_WIDTH bits
  function automatic logic [MAX_WIDTH-1:0] abs_mag(input logic [MAX_WIDTH-1:0] v, input int w);
    logic [MAX_WIDTH-1:0] m;
    m = (w >= MAX_WIDTH) ? '1 : ((MAX_WIDTH'(1) << w) - MAX_WIDTH'(1));
    return v[w-1] ? ((~v + MAX_WIDTH'(1)) & m) : v;
  endfunction
endpackage

// File: rtl/seq_mult_nxn_if.sv
// seq_mult_nxn_if: start/busy/done operand-result bundle; is_signed exists only with SEQ_MULT_SIGNED_EN.
interface seq_mult_nxn_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
`ifdef SEQ_MULT_SIGNED_EN
  logic is_signed;
`endif
  logic busy;
  logic done;
  logic [2*WIDTH-1:0] p;
  modport master (
`ifdef SEQ_MULT_SIGNED_EN
    output is_signed,
`endif
    output start, x, y,
    input busy, done, p
  );
  modport slave (
`ifdef SEQ_MULT_SIGNED_EN
    input is_signed,
`endif
    input start, x, y,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mult_nxn.sv
// seq_mult_nxn: WIDTH x WIDTH shift-add multiplier, one result per WIDTH+1 cycles.
// SEQ_MULT_SIGNED_EN adds two's complement operands via magnitude/sign handling.
module seq_mult_nxn
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  seq_mult_nxn_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  state_t r_state, w_next;
  logic [2*WIDTH-1:0] r_acc, r_mcand, r_p, w_acc_nxt;
  logic [WIDTH-1:0] r_mplier, w_xm, w_ym;
  logic [CNT_W-1:0] r_cnt;
  logic r_neg, w_neg, w_accept, w_last;
`ifdef SEQ_MULT_SIGNED_EN
  always_comb begin
    w_xm = bus.is_signed ? WIDTH'(abs_mag(MAX_WIDTH'(bus.x), WIDTH)) : bus.x;
    w_ym = bus.is_signed ? WIDTH'(abs_mag(MAX_WIDTH'(bus.y), WIDTH)) : bus.y;
    w_neg = bus.is_signed & (bus.x[WIDTH-1] ^ bus.y[WIDTH-1]);
  end
`else
  always_comb begin
    w_xm = bus.x;
    w_ym = bus.y;
    w_neg = 1'b0;
  end
`endif
  assign w_accept = (r_state != RUN) && bus.start;
  assign w_last = (r_state == RUN) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  always_comb begin
    w_next = w_accept ? RUN : (r_state == RUN) ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_p <= '0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_mcand <= {{WIDTH{1'b0}}, w_xm};
      r_mplier <= w_ym;
      r_cnt <= '0;
      r_neg <= w_neg;
    end else if (r_state == RUN) begin
      r_acc <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) r_p <= r_neg ? -w_acc_nxt : w_acc_nxt;
    end
  end
  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.p = r_p;
endmodule

// File: tb/tb_seq_mult_nxn.sv
// tb_seq_mult_nxn: directed and randomized checks of seq_mult_nxn at WIDTH=8 and WIDTH=3.
module tb_seq_mult_nxn;
  logic clk = 1'b0;
  logic rst;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  seq_mult_nxn_if #(.WIDTH(8)) b8();
  seq_mult_nxn_if #(.WIDTH(3)) b3();
  seq_mult_nxn #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(b8.slave));
  seq_mult_nxn #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(b3.slave));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    int pr;
    if (sg) pr = int'($signed(a)) * int'($signed(b));
    else pr = int'(a) * int'(b);
    return 16'(pr);
  endfunction

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic sg);
    b8.x = a;
    b8.y = b;
`ifdef SEQ_MULT_SIGNED_EN
    b8.is_signed = sg;
`else
    if (sg) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  // Called and returns at a falling edge; operands are scrambled after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sg, input string tag);
    logic [15:0] e;
    e = ref8(a, b, sg);
    b8.start = 1'b1;
    drive8(a, b, sg);
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    drive8(8'($urandom), 8'($urandom), 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, b8.busy, 1);
      chk({tag, "_nodone"}, b8.done, 0);
    end
    @(negedge clk);
    chk({tag, "_done"}, b8.done, 1);
    chk({tag, "_busy_off"}, b8.busy, 0);
    chk({tag, "_p"}, b8.p, e);
    @(negedge clk);
    chk({tag, "_done_pulse"}, b8.done, 0);
    chk({tag, "_p_held"}, b8.p, e);
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b);
    b3.start = 1'b1;
    b3.x = a;
    b3.y = b;
    @(posedge clk);
    #1;
    b3.start = 1'b0;
    b3.x = 3'($urandom);
    b3.y = 3'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (b3.busy !== 1'b1 || b3.done !== 1'b0) chk("w3_run", {b3.busy, b3.done}, 2'b10);
    end
    @(negedge clk);
    chk("w3_done", b3.done, 1);
    chk("w3_p", b3.p, 64'(a) * 64'(b));
    @(negedge clk);
    if (b3.done !== 1'b0) chk("w3_pulse", b3.done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone, first;
    logic [15:0] q_exp;
    rst = 1'b1;
    b8.start = 1'b0;
    drive8(8'd0, 8'd0, 1'b0);
    b3.start = 1'b0;
    b3.x = '0;
    b3.y = '0;
`ifdef SEQ_MULT_SIGNED_EN
    b3.is_signed = 1'b0;
`endif
    @(negedge clk);
    chk("rst_busy", b8.busy, 0);
    chk("rst_done", b8.done, 0);
    chk("rst_p", b8.p, 0);
    chk("rst_w3", {b3.busy, b3.done, b3.p}, 0);
    rst = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) op3(3'(a), 3'(b));
    op8(8'd255, 8'd255, 1'b0, "max");
    op8(8'd0, 8'd200, 1'b0, "zero");
    op8(8'd1, 8'd1, 1'b0, "one");
    for (int k = 0; k < 10; k++) op8(8'($urandom), 8'($urandom), 1'b0, "rand");
    // start re-pulsed mid-RUN must neither restart nor add a done
    b8.start = 1'b1;
    drive8(8'd12, 8'd13, 1'b0);
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    ndone = 0;
    first = 0;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      b8.start = (c == 3);
      if (c == 3) drive8(8'd99, 8'd99, 1'b0);
      if (b8.done) begin
        ndone++;
        if (first == 0) begin
          first = c;
          chk("ignore_p", b8.p, 156);
        end
      end
    end
    chk("ignore_ndone", ndone, 1);
    chk("ignore_lat", first, 9);
    b8.start = 1'b0;
    // async reset mid-RUN
    b8.start = 1'b1;
    drive8(8'd7, 8'd9, 1'b0);
    @(posedge clk);
    #1;
    b8.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", b8.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", b8.busy, 0);
    chk("arst_done", b8.done, 0);
    chk("arst_p", b8.p, 0);
    @(negedge clk);
    rst = 1'b0;
    op8(8'd7, 8'd9, 1'b0, "after_rst");
    // start held high: one result per 9 cycles, each from its own accepting edge
    b8.start = 1'b1;
    drive8(8'($urandom), 8'($urandom), 1'b0);
    for (int k = 0; k < 6; k++) begin
      q_exp = ref8(b8.x, b8.y, 1'b0);
      @(posedge clk);
      #1;
      drive8(8'($urandom), 8'($urandom), 1'b0);
      repeat (8) begin
        @(negedge clk);
        if (b8.busy !== 1'b1) chk("b2b_busy", b8.busy, 1);
      end
      @(negedge clk);
      chk("b2b_done", b8.done, 1);
      chk("b2b_p", b8.p, q_exp);
      drive8(8'($urandom), 8'($urandom), 1'b0);
    end
    b8.start = 1'b0;
    @(negedge clk);
`ifdef SEQ_MULT_SIGNED_EN
    op8(8'h80, 8'h80, 1'b1, "s_min");
    op8(8'hFD, 8'd5, 1'b1, "s_neg");
    op8(8'hFD, 8'd5, 1'b0, "s_uns");
    for (int k = 0; k < 10; k++) op8(8'($urandom), 8'($urandom), 1'b1, "s_rand");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
